// File: rtl/imem_boot_sequencer_pkg.sv
// Shared types and default geometry for the boot sequencer and the CPU top.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        FLUSH = 3'd3,
        RUN   = 3'd4
    } boot_state_t;

    localparam int BOOT_ADDR_W    = 12;
    localparam int BOOT_DEPTH     = 4096;
    localparam int BOOT_FLUSH_CYC = 3;

endpackage

// File: rtl/imem_boot_sequencer_byte_packer.sv
// Packs a byte stream into a 32-bit little-endian word; lane 0 lands in [7:0].
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  lane
);

    logic [31:0] word_r;
    logic [1:0]  lane_r;

    // Lane pointer and word assembly; lanes not yet loaded stay zero after clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r <= 32'd0;
            lane_r <= 2'd0;
        end else if (clr) begin
            word_r <= 32'd0;
            lane_r <= 2'd0;
        end else if (load) begin
            word_r[{lane_r, 3'b000} +: 8] <= byte_in;
            lane_r                        <= lane_r + 2'd1;
        end
    end

    assign word = word_r;
    assign lane = lane_r;

endmodule

// File: rtl/imem_boot_sequencer.sv
// Boot/reload controller: holds the core in reset, streams a program into
// instruction memory word by word, flushes the pipeline, then releases the core.
module imem_boot_sequencer
    import boot_pkg::*;
#(
    parameter int ADDR_W    = BOOT_ADDR_W,
    parameter int DEPTH     = BOOT_DEPTH,
    parameter int FLUSH_CYC = BOOT_FLUSH_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done
);

    localparam int                FC_W    = $clog2(FLUSH_CYC + 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] WC_ONE  = ADDR_W'(1);
    localparam logic [FC_W-1:0]   FLUSH_L = FC_W'(FLUSH_CYC);
    localparam logic [FC_W-1:0]   FC_ONE  = FC_W'(1);

    boot_state_t       state_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W-1:0] wc_r;
    logic [FC_W-1:0]   fc_r;
    logic              byte_ready_r, imem_we_r, cpu_rst_r, busy_r, done_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;

    logic              accept_s, start_ok_s, clr_s, last_word_s;
    logic [ADDR_W:0]   start_len_s;
    logic [31:0]       word_s;
    logic [1:0]        lane_s;

    byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_s),
        .load    (accept_s),
        .byte_in (byte_in),
        .word    (word_s),
        .lane    (lane_s)
    );

    // Handshake, start qualification and length clamping.
    always_comb begin
        accept_s    = (state_r == RECV) && byte_valid && byte_ready_r;
        start_ok_s  = start && ((state_r == IDLE) || (state_r == RUN));
        clr_s       = start_ok_s || (state_r == WRITE);
        last_word_s = ({1'b0, wc_r} == (len_r - LEN_ONE));
        if (load_len > DEPTH_L) begin
            start_len_s = DEPTH_L;
        end else begin
            start_len_s = load_len;
        end
    end

    // Sequencer FSM with word counter, flush counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            len_r        <= '0;
            wc_r         <= '0;
            fc_r         <= '0;
            byte_ready_r <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'd0;
            cpu_rst_r    <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            imem_we_r <= 1'b0;
            case (state_r)
                IDLE, RUN: begin
                    if (start_ok_s) begin
                        len_r     <= start_len_s;
                        wc_r      <= '0;
                        cpu_rst_r <= 1'b1;
                        done_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        if (start_len_s == '0) begin
                            state_r <= FLUSH;
                            fc_r    <= FLUSH_L;
                        end else begin
                            state_r      <= RECV;
                            byte_ready_r <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    // Lane 3 of the packer is still clear, so the arriving byte is OR-ed in.
                    if (accept_s && (lane_s == 2'd3)) begin
                        state_r      <= WRITE;
                        byte_ready_r <= 1'b0;
                        imem_we_r    <= 1'b1;
                        imem_addr_r  <= wc_r;
                        imem_wdata_r <= {word_s[31:24] | byte_in, word_s[23:0]};
                    end
                end
                WRITE: begin
                    wc_r <= wc_r + WC_ONE;
                    if (last_word_s) begin
                        state_r <= FLUSH;
                        fc_r    <= FLUSH_L;
                    end else begin
                        state_r      <= RECV;
                        byte_ready_r <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (fc_r == FC_ONE) begin
                        state_r   <= RUN;
                        cpu_rst_r <= 1'b0;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                    end else begin
                        fc_r <= fc_r - FC_ONE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    byte_ready_r <= 1'b0;
                    cpu_rst_r    <= 1'b1;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// plus directed loads with hand-computed expectations.
module tb_imem_boot_sequencer;

    localparam int ADDR_W    = 12;
    localparam int DEPTH     = 4096;
    localparam int FLUSH_CYC = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready, imem_we, cpu_rst, busy, done;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // observed memory writes
    logic [31:0] obs_mem [int];
    int          obs_cnt = 0;
    int          last_we_cyc = 0;
    int          last_addr = -1;

    logic [7:0] pbytes [$];

    // reference model state
    bit          m_active, m_write, m_run;
    int          m_flush, m_total, m_got;
    logic [7:0]  m_q [$];
    logic        e_ready, e_we, e_cpu_rst, e_busy, e_done;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0] e_data;

    imem_boot_sequencer #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_write = 1'b0; m_run = 1'b0;
        m_flush = 0; m_total = 0; m_got = 0;
        m_q.delete();
        e_ready = 1'b0; e_we = 1'b0; e_cpu_rst = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        e_addr = '0; e_data = 32'd0;
    endtask

    // Advance the model over one clock edge using the inputs seen at that edge.
    task automatic model_step();
        int len;
        if (rst) begin
            model_reset();
            return;
        end
        e_we = 1'b0;
        if (m_write) begin
            m_write = 1'b0;
            if (m_got == m_total) begin
                m_active = 1'b0;
                m_flush  = FLUSH_CYC;
            end
        end else if (m_flush > 0) begin
            m_flush--;
            if (m_flush == 0) m_run = 1'b1;
        end else if (m_active) begin
            if (byte_valid) begin
                m_q.push_back(byte_in);
                m_got++;
                if (m_q.size() == 4) begin
                    e_we    = 1'b1;
                    e_addr  = ADDR_W'(m_got / 4 - 1);
                    e_data  = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_q.delete();
                    m_write = 1'b1;
                end
            end
        end else if (start) begin
            len     = (int'(load_len) > DEPTH) ? DEPTH : int'(load_len);
            m_run   = 1'b0;
            m_total = 4 * len;
            m_got   = 0;
            m_q.delete();
            if (len == 0) m_flush = FLUSH_CYC;
            else          m_active = 1'b1;
        end
        e_ready   = m_active && !m_write;
        e_busy    = m_active || (m_flush > 0);
        e_done    = m_run;
        e_cpu_rst = !m_run;
    endtask

    // Compare process: model update at each edge, check all outputs 1 time unit later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            chk1("byte_ready", byte_ready, e_ready);
            chk1("imem_we", imem_we, e_we);
            chk32("imem_addr", 32'(imem_addr), 32'(e_addr));
            chk32("imem_wdata", imem_wdata, e_data);
            chk1("cpu_rst", cpu_rst, e_cpu_rst);
            chk1("busy", busy, e_busy);
            chk1("done", done, e_done);
            if (imem_we === 1'b1) begin
                obs_mem[int'(imem_addr)] = imem_wdata;
                obs_cnt++;
                last_we_cyc = cyc;
                last_addr   = int'(imem_addr);
            end
        end
    end

    task automatic pulse_start(input int len, output int t);
        @(negedge clk);
        start    = 1'b1;
        load_len = (ADDR_W + 1)'(len);
        t        = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer pbytes[0..n-1]; entered and left on a falling edge.
    task automatic stream(input int n, input bit toggle);
        int i = 0;
        int c = 0;
        bit ph = 1'b1;
        while (i < n && c < 4 * n + 40) begin
            byte_valid = toggle ? ph : 1'b1;
            byte_in    = pbytes[i];
            ph         = ~ph;
            #4;
            if (byte_valid && byte_ready) i++;
            c++;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        chk32("stream_bytes_accepted", i, n);
    endtask

    task automatic wait_done(output int c);
        int k = 0;
        while (done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        c = cyc;
        chk1("wait_done", done, 1'b1);
    endtask

    initial begin
        int t0, rc, base;

        @(negedge clk);
        chk1("rst_cpu_rst", cpu_rst, 1'b1);
        chk1("rst_byte_ready", byte_ready, 1'b0);
        chk1("rst_we", imem_we, 1'b0);
        chk32("rst_addr", 32'(imem_addr), 32'd0);
        chk32("rst_wdata", imem_wdata, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // two-word load, back-to-back bytes
        pbytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        base = obs_cnt;
        pulse_start(2, t0);
        stream(8, 1'b0);
        wait_done(rc);
        chk32("t1_write_count", obs_cnt - base, 32'd2);
        chk32("t1_word0", obs_mem[0], 32'h0000_0013);
        chk32("t1_word1", obs_mem[1], 32'h0010_0093);
        chk32("t1_last_addr", last_addr, 32'd1);
        chk32("t1_cpu_rst_fall", rc - last_we_cyc, 32'd4);
        chk1("t1_done", done, 1'b1);
        chk1("t1_cpu_rst_low", cpu_rst, 1'b0);

        // same load with byte_valid toggling (hot reload from RUN)
        obs_mem[0] = 32'hFFFF_FFFF;
        obs_mem[1] = 32'hFFFF_FFFF;
        base = obs_cnt;
        pulse_start(2, t0);
        stream(8, 1'b1);
        wait_done(rc);
        chk32("t2_write_count", obs_cnt - base, 32'd2);
        chk32("t2_word0", obs_mem[0], 32'h0000_0013);
        chk32("t2_word1", obs_mem[1], 32'h0010_0093);
        chk32("t2_cpu_rst_fall", rc - last_we_cyc, 32'd4);

        // zero-length load
        base = obs_cnt;
        pulse_start(0, t0);
        wait_done(rc);
        chk32("t3_no_write", obs_cnt - base, 32'd0);
        chk32("t3_run_latency", rc - t0, 32'd4);

        // asynchronous reset after 6 bytes of a 2-word load
        pbytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        base = obs_cnt;
        pulse_start(2, t0);
        stream(6, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk1("t5_cpu_rst", cpu_rst, 1'b1);
        chk1("t5_byte_ready", byte_ready, 1'b0);
        chk1("t5_we", imem_we, 1'b0);
        chk32("t5_addr", 32'(imem_addr), 32'd0);
        chk32("t5_wdata", imem_wdata, 32'd0);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk32("t5_write_count", obs_cnt - base, 32'd1);
        chk32("t5_last_addr", last_addr, 32'd0);

        // one-word load to reach RUN, then hot reload with start held during RECV
        pbytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pulse_start(1, t0);
        stream(4, 1'b0);
        wait_done(rc);
        chk32("t6_first_word", obs_mem[0], 32'hDEAD_BEEF);
        pbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        base = obs_cnt;
        pulse_start(2, t0);
        chk1("t6_cpu_rst_next", cpu_rst, 1'b1);
        chk1("t6_done_low", done, 1'b0);
        start    = 1'b1;
        load_len = '0;
        stream(8, 1'b0);
        start = 1'b0;
        wait_done(rc);
        chk32("t6_write_count", obs_cnt - base, 32'd2);
        chk32("t6_word0", obs_mem[0], 32'h4433_2211);
        chk32("t6_word1", obs_mem[1], 32'h8877_6655);

        // oversize load clamps to DEPTH words
        pbytes.delete();
        for (int i = 0; i < 4 * DEPTH; i++) begin
            pbytes.push_back(8'((i * 7) + (i >> 8)));
        end
        base = obs_cnt;
        pulse_start(5000, t0);
        stream(4 * DEPTH, 1'b0);
        wait_done(rc);
        chk32("t4_write_count", obs_cnt - base, 32'd4096);
        chk32("t4_last_addr", last_addr, 32'd4095);
        chk32("t4_word0", obs_mem[0], 32'h150E_0700);
        chk32("t4_word_last", obs_mem[DEPTH - 1],
              {pbytes[4 * DEPTH - 1], pbytes[4 * DEPTH - 2], pbytes[4 * DEPTH - 3], pbytes[4 * DEPTH - 4]});
        byte_valid = 1'b1;
        byte_in    = 8'hA5;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk1("t4_surplus_ready", byte_ready, 1'b0);
        end
        byte_valid = 1'b0;
        chk1("t4_done", done, 1'b1);
        chk32("t4_no_extra_write", obs_cnt - base, 32'd4096);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
